pipe_fwd_ctrl: RTL and testbench

//  Consumer end of the hazard-detect interface. Takes the NOP / PC-stall / 6-bit forward

---
 rtl/pipe_fwd_ctrl_pkg.sv | 26 ++
 rtl/pipe_fwd_ctrl_dff.sv | 21 ++
 rtl/pipe_fwd_ctrl_fwd_mux3.sv | 22 ++
 rtl/pipe_fwd_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_pipe_fwd_ctrl.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/pipe_fwd_ctrl_pkg.sv
// Shared encodings for the pipeline forward/hazard consumer.
// FSM states, hz_fwd bit positions and the pipeline NOP word.
package pipe_fwd_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HAZ    = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_FREEZE = 2'd3
  } state_e;

  // hz_fwd = {EXtoEX_Rs,MEMtoEX_Rs,EXtoEX_Rt,MEMtoEX_Rt,EXtoID_Rs,MEMtoID_Rs}
  localparam int FWD_EXEX_RS  = 5;
  localparam int FWD_MEMEX_RS = 4;
  localparam int FWD_EXEX_RT  = 3;
  localparam int FWD_MEMEX_RT = 2;
  localparam int FWD_EXID_RS  = 1;
  localparam int FWD_MEMID_RS = 0;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/pipe_fwd_ctrl_dff.sv
// Enabled D flip-flop cell with synchronous active-high clear.
// Every state, counter and pipeline register is built from it.
module dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_fwd_ctrl_fwd_mux3.sv
// Three-way priority forward mux: a beats b beats the default.
module fwd_mux3 #(
  parameter int W = 16
) (
  input  logic         sel_hi,
  input  logic         sel_lo,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] dflt,
  output logic [W-1:0] y
);

  always_comb begin
    y = dflt;
    if (sel_hi) begin
      y = a;
    end else if (sel_lo) begin
      y = b;
    end
  end

endmodule

// File: rtl/pipe_fwd_ctrl.sv
// Hazard-request consumer: PC/IF-ID enables, bubble/flush,
// branch flush sequencing, dmem freeze and operand forwarding.
module pipe_fwd_ctrl
  import pipe_fwd_ctrl_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int FLUSH_CYC = 2,
  parameter int MAX_STALL = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hz_nop,
  input  logic             hz_pc_stall,
  input  logic [5:0]       hz_fwd,
  input  logic             br_taken,
  input  logic             dmem_stall,
  input  logic [WIDTH-1:0] id_rs_data,
  input  logic [WIDTH-1:0] id_rt_data,
  input  logic [WIDTH-1:0] exmem_result,
  input  logic [WIDTH-1:0] memwb_result,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [WIDTH-1:0] jr_base,
  output logic [WIDTH-1:0] ex_opA,
  output logic [WIDTH-1:0] ex_opB,
  output logic             stall_err
);

  localparam logic [1:0] FLUSH_LD  = 2'(FLUSH_CYC - 1);
  localparam logic [3:0] STALL_LIM = 4'(MAX_STALL - 1);

  logic [1:0]       state_q, state_d;
  logic [1:0]       saved_q, saved_d;
  logic [1:0]       cur;
  logic [1:0]       flush_cnt_q, flush_cnt_d;
  logic [3:0]       stall_cnt_q, stall_cnt_d;
  logic             stall_err_q, stall_err_d;
  logic [5:0]       fwd_id_q, fwd_id_d;
  logic [3:0]       fwd_ex_q, fwd_ex_d;
  logic [WIDTH-1:0] ex_rs_q, ex_rs_d;
  logic [WIDTH-1:0] ex_rt_q, ex_rt_d;
  logic             in_flush;
  logic             ex_adv;
  logic [WIDTH-1:0] jr_y, opa_y, opb_y;

  // Releasing a freeze resumes the saved state in the same cycle.
  assign cur      = (state_q == ST_FREEZE) ? saved_q : state_q;
  assign in_flush = (cur == ST_FLUSH) && (flush_cnt_q != 2'd0);
  assign ex_adv   = ~dmem_stall;

  always_comb begin
    pc_we        = 1'b1;
    if_id_we     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = hz_nop;
    state_d      = ST_RUN;
    saved_d      = saved_q;
    flush_cnt_d  = flush_cnt_q;
    stall_cnt_d  = 4'd0;
    stall_err_d  = stall_err_q;
    priority case (1'b1)
      rst: begin
        pc_we        = 1'b0;
        if_id_we     = 1'b0;
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        flush_cnt_d  = 2'd0;
        stall_err_d  = 1'b0;
      end
      dmem_stall: begin
        pc_we        = 1'b0;
        if_id_we     = 1'b0;
        id_ex_bubble = 1'b0;
        state_d      = ST_FREEZE;
        saved_d      = cur;
        stall_cnt_d  = stall_cnt_q;
      end
      br_taken: begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        state_d      = ST_FLUSH;
        flush_cnt_d  = FLUSH_LD;
      end
      in_flush: begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        state_d      = ST_FLUSH;
        flush_cnt_d  = flush_cnt_q - 2'd1;
      end
      hz_pc_stall: begin
        pc_we        = 1'b0;
        if_id_we     = 1'b0;
        id_ex_bubble = 1'b1;
        state_d      = ST_HAZ;
        stall_cnt_d  = sat_inc4(stall_cnt_q);
        if (stall_cnt_q == STALL_LIM) begin
          stall_err_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_comb begin
    fwd_id_d = fwd_id_q;
    if (if_id_flush) begin
      fwd_id_d = 6'd0;
    end else if (if_id_we) begin
      fwd_id_d = hz_fwd;
    end
    fwd_ex_d = id_ex_bubble ? 4'd0
             : fwd_id_q[FWD_EXEX_RS:FWD_MEMEX_RT];
    ex_rs_d  = id_ex_bubble ? '0 : id_rs_data;
    ex_rt_d  = id_ex_bubble ? '0 : id_rt_data;
  end

  dff #(.W(2)) u_state (
    .clk(clk), .rst(rst), .en(1'b1),
    .d(state_d), .q(state_q)
  );

  dff #(.W(2)) u_saved (
    .clk(clk), .rst(rst), .en(1'b1),
    .d(saved_d), .q(saved_q)
  );

  dff #(.W(2)) u_flush_cnt (
    .clk(clk), .rst(rst), .en(1'b1),
    .d(flush_cnt_d), .q(flush_cnt_q)
  );

  dff #(.W(4)) u_stall_cnt (
    .clk(clk), .rst(rst), .en(1'b1),
    .d(stall_cnt_d), .q(stall_cnt_q)
  );

  dff #(.W(1)) u_stall_err (
    .clk(clk), .rst(rst), .en(1'b1),
    .d(stall_err_d), .q(stall_err_q)
  );

  dff #(.W(6)) u_fwd_id (
    .clk(clk), .rst(rst), .en(1'b1),
    .d(fwd_id_d), .q(fwd_id_q)
  );

  dff #(.W(4)) u_fwd_ex (
    .clk(clk), .rst(rst), .en(ex_adv),
    .d(fwd_ex_d), .q(fwd_ex_q)
  );

  dff #(.W(WIDTH)) u_ex_rs (
    .clk(clk), .rst(rst), .en(ex_adv),
    .d(ex_rs_d), .q(ex_rs_q)
  );

  dff #(.W(WIDTH)) u_ex_rt (
    .clk(clk), .rst(rst), .en(ex_adv),
    .d(ex_rt_d), .q(ex_rt_q)
  );

  fwd_mux3 #(.W(WIDTH)) u_mux_jr (
    .sel_hi(fwd_id_q[FWD_EXID_RS]),
    .sel_lo(fwd_id_q[FWD_MEMID_RS]),
    .a(exmem_result),
    .b(memwb_result),
    .dflt(id_rs_data),
    .y(jr_y)
  );

  fwd_mux3 #(.W(WIDTH)) u_mux_a (
    .sel_hi(fwd_ex_q[FWD_EXEX_RS - FWD_MEMEX_RT]),
    .sel_lo(fwd_ex_q[FWD_MEMEX_RS - FWD_MEMEX_RT]),
    .a(exmem_result),
    .b(memwb_result),
    .dflt(ex_rs_q),
    .y(opa_y)
  );

  fwd_mux3 #(.W(WIDTH)) u_mux_b (
    .sel_hi(fwd_ex_q[FWD_EXEX_RT - FWD_MEMEX_RT]),
    .sel_lo(fwd_ex_q[0]),
    .a(exmem_result),
    .b(memwb_result),
    .dflt(ex_rt_q),
    .y(opb_y)
  );

  assign jr_base   = rst ? '0 : jr_y;
  assign ex_opA    = rst ? '0 : opa_y;
  assign ex_opB    = rst ? '0 : opb_y;
  assign stall_err = stall_err_q;

endmodule

// File: tb/tb_pipe_fwd_ctrl.sv
// Directed table-driven bench for pipe_fwd_ctrl.
// Each row is one clock: inputs plus the outputs expected that cycle.
module tb_pipe_fwd_ctrl;

  localparam int W = 16;
  localparam logic [W-1:0] EXM = 16'hBEEF;
  localparam logic [W-1:0] MWB = 16'hCAFE;
  localparam logic [W-1:0] A   = 16'h1111;
  localparam logic [W-1:0] B   = 16'h2222;
  localparam logic [W-1:0] C   = 16'h3333;
  localparam logic [W-1:0] D   = 16'h4444;
  localparam logic [W-1:0] E   = 16'h5555;
  localparam logic [W-1:0] G   = 16'h7777;
  localparam logic [W-1:0] H   = 16'h9999;
  localparam logic [W-1:0] Z   = 16'h0000;

  logic         clk = 1'b0;
  logic         rst, hz_nop, hz_pc_stall, br_taken, dmem_stall;
  logic [5:0]   hz_fwd;
  logic [W-1:0] id_rs_data, id_rt_data, exmem_result, memwb_result;
  logic         pc_we, if_id_we, if_id_flush, id_ex_bubble, stall_err;
  logic [W-1:0] jr_base, ex_opA, ex_opB;

  typedef struct {
    logic         rst, nop, stl, br, dm;
    logic [5:0]   fwd;
    logic [W-1:0] rs, rt;
    logic         pc, ifw, fl, bub, err;
    logic         dck;
    logic [W-1:0] jr, opa, opb;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  pipe_fwd_ctrl #(.WIDTH(W), .FLUSH_CYC(2), .MAX_STALL(8)) dut (
    .clk(clk), .rst(rst),
    .hz_nop(hz_nop), .hz_pc_stall(hz_pc_stall), .hz_fwd(hz_fwd),
    .br_taken(br_taken), .dmem_stall(dmem_stall),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .exmem_result(exmem_result), .memwb_result(memwb_result),
    .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .jr_base(jr_base),
    .ex_opA(ex_opA), .ex_opB(ex_opB), .stall_err(stall_err)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic [4:0] ci, input logic [5:0] f,
    input logic [W-1:0] rs_, input logic [W-1:0] rt_,
    input logic [4:0] co, input logic dk,
    input logic [W-1:0] jr_, input logic [W-1:0] oa,
    input logic [W-1:0] ob
  );
    vec_t v;
    {v.rst, v.nop, v.stl, v.br, v.dm} = ci;
    {v.pc, v.ifw, v.fl, v.bub, v.err} = co;
    v.fwd = f; v.rs = rs_; v.rt = rt_;
    v.dck = dk; v.jr = jr_; v.opa = oa; v.opb = ob;
    return v;
  endfunction

  task automatic add(
    input logic [4:0] ci, input logic [5:0] f,
    input logic [W-1:0] rs_, input logic [W-1:0] rt_,
    input logic [4:0] co, input logic dk,
    input logic [W-1:0] jr_, input logic [W-1:0] oa,
    input logic [W-1:0] ob
  );
    tbl.push_back(mk(ci, f, rs_, rt_, co, dk, jr_, oa, ob));
  endtask

  task automatic chk1(input int i, input string nm,
                      input logic act, input logic exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL vec %0d %s: got %b expected %b", i, nm, act, exp);
    end
  endtask

  task automatic chkw(input int i, input string nm,
                      input logic [W-1:0] act, input logic [W-1:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL vec %0d %s: got %h expected %h", i, nm, act, exp);
    end
  endtask

  // Inputs driven just after negedge, outputs sampled 2ns later.
  task automatic apply(input vec_t v, input int i);
    rst = v.rst; hz_nop = v.nop; hz_pc_stall = v.stl;
    br_taken = v.br; dmem_stall = v.dm; hz_fwd = v.fwd;
    id_rs_data = v.rs; id_rt_data = v.rt;
    exmem_result = EXM; memwb_result = MWB;
    #2;
    n_vec++;
    chk1(i, "pc_we", pc_we, v.pc);
    chk1(i, "if_id_we", if_id_we, v.ifw);
    chk1(i, "if_id_flush", if_id_flush, v.fl);
    chk1(i, "id_ex_bubble", id_ex_bubble, v.bub);
    chk1(i, "stall_err", stall_err, v.err);
    if (v.dck) begin
      chkw(i, "jr_base", jr_base, v.jr);
      chkw(i, "ex_opA", ex_opA, v.opa);
      chkw(i, "ex_opB", ex_opB, v.opb);
    end
    @(negedge clk);
  endtask

  task automatic step(
    input int i, input logic [4:0] ci, input logic [5:0] f,
    input logic [4:0] co, input logic dk,
    input logic [W-1:0] jr_, input logic [W-1:0] oa,
    input logic [W-1:0] ob
  );
    apply(mk(ci, f, A, B, co, dk, jr_, oa, ob), i);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ci = {rst,nop,stl,br,dm}; co = {pc_we,if_id_we,flush,bubble,err}
    add(5'b10000, 6'b000000, A, B, 5'b00110, 1, Z, Z, Z);
    add(5'b00000, 6'b000000, A, B, 5'b11000, 1, A, Z, Z);
    add(5'b00000, 6'b100000, A, B, 5'b11000, 1, A, A, B);
    add(5'b00000, 6'b000000, C, D, 5'b11000, 1, C, A, B);
    add(5'b00000, 6'b110000, A, B, 5'b11000, 1, A, EXM, D);
    add(5'b00000, 6'b000110, E, B, 5'b11000, 1, E, A, B);
    add(5'b00000, 6'b001001, A, B, 5'b11000, 1, EXM, EXM, B);
    add(5'b00000, 6'b000000, A, B, 5'b11000, 1, MWB, A, MWB);
    add(5'b00000, 6'b000000, A, B, 5'b11000, 1, A, A, EXM);
    add(5'b01000, 6'b000000, A, B, 5'b11010, 1, A, A, B);
    add(5'b00000, 6'b100001, A, B, 5'b11000, 1, A, Z, Z);
    // three-cycle hazard stall; hz_fwd ignored while IF/ID held
    add(5'b00100, 6'b000011, A, B, 5'b00010, 1, MWB, A, B);
    add(5'b00100, 6'b000000, A, B, 5'b00010, 1, MWB, Z, Z);
    add(5'b00100, 6'b000000, A, B, 5'b00010, 1, MWB, Z, Z);
    add(5'b00000, 6'b000000, A, B, 5'b11000, 1, MWB, Z, Z);
    add(5'b00000, 6'b000000, A, B, 5'b11000, 1, A, EXM, B);
    // branch flush, two cycles, beats a simultaneous stall
    add(5'b00110, 6'b111111, A, B, 5'b11110, 1, A, A, B);
    add(5'b00000, 6'b111111, A, B, 5'b11110, 1, A, Z, Z);
    add(5'b00000, 6'b000000, A, B, 5'b11000, 1, A, Z, Z);
    add(5'b00000, 6'b000000, A, B, 5'b11000, 1, A, A, B);
    // second branch in flush cycle 2 reloads the counter
    add(5'b00010, 6'b000000, A, B, 5'b11110, 1, A, A, B);
    add(5'b00010, 6'b000000, A, B, 5'b11110, 1, A, Z, Z);
    add(5'b00000, 6'b000000, A, B, 5'b11110, 1, A, Z, Z);
    add(5'b00000, 6'b000000, A, G, 5'b11000, 1, A, Z, Z);
    // freeze in mid-flush for 4 cycles
    add(5'b00010, 6'b000000, A, B, 5'b11110, 1, A, A, G);
    add(5'b00011, 6'b000000, A, B, 5'b00000, 1, A, Z, Z);
    add(5'b00101, 6'b111111, A, B, 5'b00000, 1, A, Z, Z);
    add(5'b00001, 6'b000000, A, B, 5'b00000, 1, A, Z, Z);
    add(5'b00001, 6'b000000, A, B, 5'b00000, 1, A, Z, Z);
    add(5'b00000, 6'b000000, A, B, 5'b11110, 1, A, Z, Z);
    add(5'b00000, 6'b000000, A, H, 5'b11000, 1, A, Z, Z);
    // freeze in RUN: EX operands hold, bubble suppressed
    add(5'b00001, 6'b000000, A, B, 5'b00000, 1, A, A, H);
    add(5'b01001, 6'b111111, A, B, 5'b00000, 1, A, A, H);
    add(5'b00000, 6'b000000, A, B, 5'b11000, 1, A, A, H);

    rst = 1'b1; hz_nop = 1'b0; hz_pc_stall = 1'b0;
    br_taken = 1'b0; dmem_stall = 1'b0; hz_fwd = 6'd0;
    id_rs_data = A; id_rt_data = B;
    exmem_result = EXM; memwb_result = MWB;
    repeat (2) @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], i);
    end

    // MAX_STALL-1 stalls stay clean; the counter clears on release
    for (int i = 0; i < 7; i++) begin
      step(100 + i, 5'b00100, 6'd0, 5'b00010, 0, Z, Z, Z);
    end
    step(107, 5'b00000, 6'd0, 5'b11000, 0, Z, Z, Z);
    for (int i = 0; i < 8; i++) begin
      step(108 + i, 5'b00100, 6'd0, 5'b00010, 0, Z, Z, Z);
    end
    // sticky error, then reset mid-HAZ with EX forwards live
    step(116, 5'b00000, 6'b101010, 5'b11001, 1, A, Z, Z);
    step(117, 5'b00000, 6'b000000, 5'b11001, 1, EXM, A, B);
    step(118, 5'b00100, 6'b000000, 5'b00011, 1, A, EXM, EXM);
    step(119, 5'b10100, 6'b000000, 5'b00111, 1, Z, Z, Z);
    step(120, 5'b00000, 6'b000000, 5'b11000, 1, A, Z, Z);
    step(121, 5'b00000, 6'b000000, 5'b11000, 1, A, A, B);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
